// File: rtl/lsm_pv_reduce.sv
// Path-value reduction stage for the LSM pricer: accumulates the clamped
// per-path PV and its square over a batch, then produces the mean
// (price estimate) and the second-moment variance in signed fixed point.

package fpga_cfg_pkg;
    localparam int FP_WIDTH = 32;
    localparam int FP_QINT  = 15;
    localparam int FP_QFRAC = 16;
endpackage

module lsm_pv_reduce #(
    parameter int WIDTH   = fpga_cfg_pkg::FP_WIDTH,
    parameter int QINT    = fpga_cfg_pkg::FP_QINT,
    parameter int QFRAC   = fpga_cfg_pkg::FP_QFRAC,
    parameter int N_PATHS = 1024,
    parameter int LANE_ID = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               valid_in,
    output logic                               ready_out,
    input  logic signed [WIDTH-1:0]            PV,
    output logic                               valid_out,
    input  logic                               ready_in,
    output logic signed [WIDTH-1:0]            price,
    output logic signed [WIDTH-1:0]            variance,
    output logic [$clog2(N_PATHS+1)-1:0]       path_count,
    output logic                               err_neg
);

    localparam int LOGN   = $clog2(N_PATHS);
    localparam int SUM_W  = WIDTH + LOGN;
    localparam int SQ_W   = 2 * WIDTH - QFRAC + LOGN;
    localparam int CNT_W  = $clog2(N_PATHS + 1);
    // Wide enough for either accumulator times the reciprocal constant.
    localparam int PROD_W = SQ_W + QFRAC + 2;
    // Reciprocal of the batch size in Q(.QFRAC), rounded to nearest.
    localparam longint INV_N = ((longint'(1) << QFRAC) + longint'(N_PATHS / 2))
                               / longint'(N_PATHS);

    // A misconfigured instance shows up as this marker scope in the hierarchy.
    if (N_PATHS < 2 || LANE_ID < 0 || QINT + QFRAC + 1 != WIDTH) begin : g_cfg_unusual
    end

    typedef enum logic [1:0] {ACCUM, FIN1, FIN2, HOLD} state_t;

    state_t                   state_q;
    logic signed [SUM_W-1:0]  sum_q;
    logic signed [SQ_W-1:0]   sumsq_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [WIDTH-1:0]  mean_q;
    logic signed [WIDTH-1:0]  m2_q;
    logic signed [WIDTH-1:0]  price_q;
    logic signed [WIDTH-1:0]  var_q;
    logic                     valid_q;
    logic                     err_q;

    logic                      accept;
    logic signed [WIDTH-1:0]   p_clamp;
    logic signed [2*WIDTH-1:0] sq_full;
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [SQ_W-1:0]    sumsq_d;
    logic signed [PROD_W-1:0]  inv_ext;
    logic signed [PROD_W-1:0]  mean_prod;
    logic signed [PROD_W-1:0]  m2_prod;
    logic signed [2*WIDTH-1:0] msq_full;
    logic signed [WIDTH-1:0]   mean_d;
    logic signed [WIDTH-1:0]   m2_d;
    logic signed [WIDTH-1:0]   msq;
    logic signed [WIDTH-1:0]   var_d;

    // Clamp a wide intermediate into the signed WIDTH range.
    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [PROD_W-1:0] x);
        logic [PROD_W-WIDTH:0] top;
        top = x[PROD_W-1:WIDTH-1];
        if (top == '0 || top == '1)
            return x[WIDTH-1:0];
        else if (x[PROD_W-1])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign ready_out  = (state_q == ACCUM);
    assign valid_out  = valid_q;
    assign price      = price_q;
    assign variance   = var_q;
    assign path_count = cnt_q;
    assign err_neg    = err_q;

    // Datapath arithmetic: clamped beat, square term, and finalisation math.
    always_comb begin
        accept    = valid_in && (state_q == ACCUM);
        p_clamp   = PV[WIDTH-1] ? '0 : PV;
        sq_full   = (2*WIDTH)'(p_clamp) * (2*WIDTH)'(p_clamp);
        sum_d     = sum_q + SUM_W'(p_clamp);
        sumsq_d   = sumsq_q + SQ_W'(sq_full >>> QFRAC);
        inv_ext   = PROD_W'(INV_N);
        mean_prod = PROD_W'(sum_q) * inv_ext;
        m2_prod   = PROD_W'(sumsq_q) * inv_ext;
        mean_d    = sat_w(mean_prod >>> QFRAC);
        m2_d      = sat_w(m2_prod >>> QFRAC);
        msq_full  = (2*WIDTH)'(mean_q) * (2*WIDTH)'(mean_q);
        msq       = sat_w(PROD_W'(msq_full >>> QFRAC));
        var_d     = (m2_q > msq) ? (m2_q - msq) : '0;
    end

    // Batch FSM with accumulators and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            sumsq_q <= '0;
            cnt_q   <= '0;
            mean_q  <= '0;
            m2_q    <= '0;
            price_q <= '0;
            var_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        sum_q   <= sum_d;
                        sumsq_q <= sumsq_d;
                        cnt_q   <= cnt_q + 1'b1;
                        if (PV[WIDTH-1])
                            err_q <= 1'b1;
                        if (cnt_q == CNT_W'(N_PATHS - 1))
                            state_q <= FIN1;
                    end
                end
                FIN1: begin
                    mean_q  <= mean_d;
                    m2_q    <= m2_d;
                    state_q <= FIN2;
                end
                FIN2: begin
                    price_q <= mean_q;
                    var_q   <= var_d;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (valid_q && ready_in) begin
                        valid_q <= 1'b0;
                        sum_q   <= '0;
                        sumsq_q <= '0;
                        cnt_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_lsm_pv_reduce.sv
// Directed bench for lsm_pv_reduce with a 4-path batch in Q15.16.
module tb_lsm_pv_reduce;

    localparam int W  = fpga_cfg_pkg::FP_WIDTH;
    localparam int QI = fpga_cfg_pkg::FP_QINT;
    localparam int QF = fpga_cfg_pkg::FP_QFRAC;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    localparam logic [31:0] Q_M1   = 32'hFFFF_0000; // -1.0
    localparam logic [31:0] Q_1    = 32'h0001_0000;
    localparam logic [31:0] Q_2    = 32'h0002_0000;
    localparam logic [31:0] Q_3    = 32'h0003_0000;
    localparam logic [31:0] Q_4    = 32'h0004_0000;
    localparam logic [31:0] Q_5    = 32'h0005_0000;
    localparam logic [31:0] Q_2P5  = 32'h0002_8000;
    localparam logic [31:0] Q_1P25 = 32'h0001_4000;
    localparam logic [31:0] Q_0P75 = 32'h0000_C000;
    localparam logic [31:0] Q_3_16 = 32'h0000_3000; // 0.1875
    localparam logic [31:0] Q_MAX  = 32'h7FFF_FFFF;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 valid_in;
    logic                 ready_out;
    logic signed [W-1:0]  pv;
    logic                 valid_out;
    logic                 ready_in;
    logic signed [W-1:0]  price;
    logic signed [W-1:0]  variance;
    logic [CW-1:0]        path_count;
    logic                 err_neg;

    int checks = 0;
    int errors = 0;

    lsm_pv_reduce #(.WIDTH(W), .QINT(QI), .QFRAC(QF), .N_PATHS(N), .LANE_ID(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .PV        (pv),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .price     (price),
        .variance  (variance),
        .path_count(path_count),
        .err_neg   (err_neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full batch with ready_in high: beats, 2-cycle finish, result, handoff.
    task automatic run_batch(input string tag, input logic [31:0] v0, input logic [31:0] v1,
                             input logic [31:0] v2, input logic [31:0] v3,
                             input logic [31:0] exp_price, input logic [31:0] exp_var,
                             input logic exp_err);
        logic [31:0] vals [4];
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        ready_in = 1'b1;
        chk({tag, " ready_out at start"}, 32'(ready_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            pv = vals[i];
            step();
            chk({tag, " path_count"}, 32'(path_count), 32'(i + 1));
        end
        valid_in = 1'b0;
        chk({tag, " ready_out in FIN1"}, 32'(ready_out), 32'd0);
        chk({tag, " valid_out in FIN1"}, 32'(valid_out), 32'd0);
        step();
        chk({tag, " valid_out 1 edge after"}, 32'(valid_out), 32'd0);
        step();
        chk({tag, " valid_out 2 edges after"}, 32'(valid_out), 32'd1);
        chk({tag, " price"}, price, exp_price);
        chk({tag, " variance"}, variance, exp_var);
        chk({tag, " err_neg"}, 32'(err_neg), 32'(exp_err));
        chk({tag, " ready_out in HOLD"}, 32'(ready_out), 32'd0);
        step();
        chk({tag, " valid_out after handoff"}, 32'(valid_out), 32'd0);
        chk({tag, " ready_out after handoff"}, 32'(ready_out), 32'd1);
        chk({tag, " path_count after handoff"}, 32'(path_count), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        pv       = '0;
        #2;
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset price", price, 32'd0);
        chk("reset variance", variance, 32'd0);
        chk("reset path_count", 32'(path_count), 32'd0);
        chk("reset err_neg", 32'(err_neg), 32'd0);
        chk("reset ready_out", 32'(ready_out), 32'd1);
        #20;
        rst_n = 1'b1;
        step();

        run_batch("ramp", Q_1, Q_2, Q_3, Q_4, Q_2P5, Q_1P25, 1'b0);
        run_batch("const3", Q_3, Q_3, Q_3, Q_3, Q_3, 32'd0, 1'b0);
        run_batch("negbeat", Q_M1, Q_1, Q_1, Q_1, Q_0P75, Q_3_16, 1'b1);

        // Result held with the consumer stalled and valid_in kept high.
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            pv = (i == 0) ? Q_1 : (i == 1) ? Q_2 : (i == 2) ? Q_3 : Q_4;
            step();
        end
        pv = Q_2;
        step();
        step();
        chk("stall valid_out rise", 32'(valid_out), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall valid_out", 32'(valid_out), 32'd1);
            chk("stall price", price, Q_2P5);
            chk("stall variance", variance, Q_1P25);
            chk("stall ready_out", 32'(ready_out), 32'd0);
            chk("stall path_count", 32'(path_count), 32'd4);
        end
        ready_in = 1'b1;
        step();
        chk("stall handoff valid_out", 32'(valid_out), 32'd0);
        chk("stall handoff path_count", 32'(path_count), 32'd0);
        chk("stall handoff ready_out", 32'(ready_out), 32'd1);
        step();
        chk("new batch first beat", 32'(path_count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        valid_in = 1'b0;
        chk("new batch count", 32'(path_count), 32'd4);
        step();
        step();
        chk("new batch valid_out", 32'(valid_out), 32'd1);
        chk("new batch price", price, Q_2);
        chk("new batch variance", variance, 32'd0);
        chk("err_neg sticky", 32'(err_neg), 32'd1);
        step();
        chk("new batch handoff", 32'(valid_out), 32'd0);

        // Reset in the middle of a batch discards the partial sums.
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1;
            pv = Q_5;
            step();
        end
        valid_in = 1'b0;
        chk("pre-reset path_count", 32'(path_count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("async reset path_count", 32'(path_count), 32'd0);
        chk("async reset err_neg", 32'(err_neg), 32'd0);
        #2;
        rst_n = 1'b1;
        run_batch("post-reset", Q_2, Q_2, Q_2, Q_2, Q_2, 32'd0, 1'b0);

        run_batch("maxword", Q_MAX, Q_MAX, Q_MAX, Q_MAX, Q_MAX, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
